usb_reg_bus_master: RTL and testbench



---
 rtl/usb_reg_bus_pkg.sv | 31 +++
 rtl/usb_reg_cmd_fifo.sv | 63 ++++++
 rtl/usb_reg_bus_master.sv | 168 ++++++++++++++++
 tb/tb_usb_reg_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_reg_bus_pkg.sv
// Shared types and constants for the usbHost register-bus initiator.
// Holds the FSM encoding, the queued command layout and the error read value.
package usb_reg_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_RESP   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  localparam logic [7:0] RD_ERR_DATA = 8'h00;

  function automatic cmd_t pack_cmd(input logic we, input logic [7:0] addr,
                                    input logic [7:0] wdata);
    cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/usb_reg_cmd_fifo.sv
// Synchronous command queue: power-of-two depth, full/empty flags, head visible
// combinationally. A push is never visible at the head in the same cycle.
module usb_reg_cmd_fifo
  import usb_reg_bus_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [CMD_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag keeps stale entries unread.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/usb_reg_bus_master.sv
// Initiator for the usbHost 8-bit register port: queues commands and runs one
// strobe/ack transaction each, returning a response with a timeout error flag.
module usb_reg_bus_master
  import usb_reg_bus_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH      = 4,
  parameter int CMD_FIFO_ADDR_WIDTH = 2,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_we,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] address_o,
  output logic [7:0] data_o,
  input  logic [7:0] data_i,
  output logic       we_o,
  output logic       strobe_o,
  input  logic       ack_i,
  output logic       busy
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;
  cmd_t             head;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       strobe_q, strobe_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_we_q, rsp_we_d;
  logic [7:0] rsp_addr_q, rsp_addr_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;

  usb_reg_cmd_fifo #(
    .DEPTH  (CMD_FIFO_DEPTH),
    .ADDR_W (CMD_FIFO_ADDR_WIDTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid),
    .wdata_i (pack_cmd(cmd_we, cmd_addr, cmd_wdata)),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head      = cmd_t'(fifo_rdata);
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

  assign strobe_o  = strobe_q;
  assign we_o      = we_q;
  assign address_o = addr_q;
  assign data_o    = data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    strobe_d    = strobe_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = head.addr;
          we_d     = head.we;
          data_d   = head.we ? head.wdata : 8'h00;
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_STROBE;
        end
      end
      ST_STROBE: begin
        // Ack is tested first so it wins over a timeout landing in the same cycle.
        if (ack_i) begin
          strobe_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          rsp_addr_d  = addr_q;
          rsp_rdata_d = we_q ? 8'h00 : data_i;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          strobe_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          rsp_addr_d  = addr_q;
          rsp_rdata_d = RD_ERR_DATA;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        // Idle cycle lets a combinational responder ack fall before the next strobe.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_addr_q  <= 8'h00;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      strobe_q    <= strobe_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_usb_reg_bus_master.sv
// Scoreboard bench for usb_reg_bus_master: a register-file responder with
// per-command wait states, an expected-response queue and a decoupled monitor.
module tb_usb_reg_bus_master;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TO    = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid, cmd_we, cmd_ready;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [7:0] rsp_addr, rsp_rdata;
  logic [7:0] address_o, data_o, data_i;
  logic       we_o, strobe_o, ack_i, busy;

  usb_reg_bus_master #(
    .CMD_FIFO_DEPTH      (DEPTH),
    .CMD_FIFO_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .address_o (address_o),
    .data_o    (data_o),
    .data_i    (data_i),
    .we_o      (we_o),
    .strobe_o  (strobe_o),
    .ack_i     (ack_i),
    .busy      (busy)
  );

  always #5 clk_i = ~clk_i;

  // wt: strobe cycles the responder waits before acking; negative = never acks.
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         wt;
    int         acc_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [256];
  logic [7:0] resp_mem  [256];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cyc  = -1000;
  int hi_cnt  = 0;
  int accepted = 0;
  int ready_mode = 0;
  bit rsp_open = 0;
  exp_t cur_cmd;
  exp_t rsp_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int exp_len(input int wt);
    return (wt >= 0 && wt < TO) ? wt + 1 : TO;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Responder plus strobe-side checks, evaluated mid-cycle.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      hi_cnt = 0;
      ack_i  = 1'b0;
    end else if (strobe_o) begin
      if (hi_cnt == 0) begin
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", 1, 0);
          cur_cmd = '{we: we_o, addr: address_o, wdata: data_o, rdata: 8'h00, err: 1'b0, wt: 0, acc_cyc: 0};
        end else begin
          cur_cmd = exp_q[0];
          check("strobe_start_cyc", cyc, imax(hs_cyc + 3, cur_cmd.acc_cyc + 2));
        end
      end
      check("strobe_addr", address_o, cur_cmd.addr);
      check("strobe_we", we_o, cur_cmd.we);
      check("strobe_data", data_o, cur_cmd.we ? cur_cmd.wdata : 8'h00);
      data_i = resp_mem[address_o];
      ack_i  = (cur_cmd.wt >= 0) && (hi_cnt == cur_cmd.wt);
      if (ack_i && we_o) resp_mem[address_o] = data_o;
      hi_cnt++;
    end else begin
      ack_i = 1'b0;
      if (hi_cnt > 0) begin
        check("strobe_len", hi_cnt, exp_len(cur_cmd.wt));
        hi_cnt = 0;
      end
    end

    // Response monitor: pops the scoreboard on first sight, re-checks while held.
    if (!rst_i && rsp_valid) begin
      check("strobe_during_rsp", strobe_o, 0);
      if (!rsp_open) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
          rsp_exp = '{we: rsp_we, addr: rsp_addr, wdata: 8'h00, rdata: rsp_rdata, err: rsp_err, wt: 0, acc_cyc: 0};
        end else begin
          rsp_exp = exp_q.pop_front();
        end
        rsp_open = 1;
      end
      check("rsp_we", rsp_we, rsp_exp.we);
      check("rsp_addr", rsp_addr, rsp_exp.addr);
      check("rsp_rdata", rsp_rdata, rsp_exp.rdata);
      check("rsp_err", rsp_err, rsp_exp.err);
      if (rsp_ready) begin
        rsp_open = 0;
        hs_cyc   = cyc;
      end
    end
  end

  // rsp_ready policy: 0 always, 1 random, 2 after 5 held cycles, 3 never.
  initial begin
    int vcnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        2: begin
          vcnt      = rsp_valid ? vcnt + 1 : 0;
          rsp_ready = (vcnt >= 6);
        end
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input int wt);
    exp_t e;
    int   tries = 0;
    bit   done  = 0;
    logic tmo;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!done) begin
      @(negedge clk_i);
      if (cmd_ready) begin
        tmo = !(wt >= 0 && wt < TO);
        e.we = we; e.addr = addr; e.wdata = wdata; e.wt = wt; e.acc_cyc = cyc;
        e.err   = tmo;
        e.rdata = (we || tmo) ? 8'h00 : model_mem[addr];
        if (we && !tmo) model_mem[addr] = wdata;
        exp_q.push_back(e);
        accepted++;
        done = 1;
      end else if (++tries > 300) begin
        n_tests++; n_fail++;
        $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, expected 1", tries);
        done = 1;
      end
      @(posedge clk_i);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while ((exp_q.size() != 0 || rsp_open || busy) && n < 3000);
    check({tag, "_drained"}, 32'(n < 3000), 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; ack_i = 1'b0; data_i = 8'h00;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'($urandom);
      resp_mem[i]  = model_mem[i];
    end
    model_mem[8'h0E] = 8'hC3;
    resp_mem[8'h0E]  = 8'hC3;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_strobe", strobe_o, 0);
    check("rst_we", we_o, 0);
    check("rst_address", address_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_we, rsp_addr, rsp_rdata, rsp_err}, 0);
    check("rst_busy", busy, 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);

    // Directed: zero-wait write, 3-wait read, timeout followed by a queued write.
    ready_mode = 0;
    issue(1'b1, 8'h01, 8'h5A, 0);
    wait_idle("wr01");
    issue(1'b0, 8'h0E, 8'h00, 3);
    wait_idle("rd0E");
    issue(1'b0, 8'h20, 8'h00, -1);
    issue(1'b1, 8'h21, 8'h77, 0);
    issue(1'b0, 8'h21, 8'h00, TO - 1);
    wait_idle("timeout");

    // Queue fill with responses held off, then drained in order.
    ready_mode = 3;
    accepted   = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(i[0], 8'h10 + 8'(i), 8'hA0 + 8'(i), i % 3);
      end
      begin
        repeat (20) @(posedge clk_i);
        #2;
        check("fill_accepted", accepted, DEPTH + 1);
        check("fill_cmd_ready", cmd_ready, 0);
        ready_mode = 1;
      end
    join
    wait_idle("fill");

    // Slow consumer.
    ready_mode = 2;
    issue(1'b0, 8'h11, 8'h00, 1);
    issue(1'b1, 8'h30, 8'h3C, 2);
    wait_idle("slow");

    // Randomized traffic with mixed wait states, timeouts and back-pressure.
    for (int i = 0; i < 40; i++) begin
      int wt;
      wt = int'($urandom_range(0, 9));
      if (wt == 9) wt = -1;
      ready_mode = (i < 20) ? 1 : 0;
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), wt);
    end
    wait_idle("random");

    // Reset during a strobe.
    ready_mode = 0;
    issue(1'b0, 8'h33, 8'h00, -1);
    for (int n = 0; n < 20 && !strobe_o; n++) @(negedge clk_i);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("midrst_strobe", strobe_o, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    rsp_open = 0;
    hs_cyc   = -1000;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("postrst_cmd_ready", cmd_ready, 1);
    check("postrst_busy", busy, 0);
    @(posedge clk_i);
    #1;
    issue(1'b1, 8'h44, 8'hA7, 1);
    issue(1'b0, 8'h44, 8'h00, 0);
    wait_idle("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
